// File: rtl/dither_sequencer_if.sv
// Pixel stream bundle: input valid/ready pixel stream plus output valid/ready pixel stream.
// master = pixel source / VGA sink side, slave = the dither sequencer itself.
interface dither_sequencer_if;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data;
  logic        s_sof;
  logic        m_valid;
  logic        m_ready;
  logic [11:0] m_data;
  logic        m_sof;
  logic        m_eol;

  modport master (
    output s_valid, s_data, s_sof, m_ready,
    input  s_ready, m_valid, m_data, m_sof, m_eol
  );

  modport slave (
    input  s_valid, s_data, s_sof, m_ready,
    output s_ready, m_valid, m_data, m_sof, m_eol
  );
endinterface

// File: rtl/dither_sequencer.sv
// Purpose: 24-bit RGB to 12-bit RGB with 2x2 Bayer ordered dither and saturation; optional DITHER_TEMPORAL_EN rotates the pattern per frame.
// Latency: 2 clocks (input register stage, output register stage); 1 pixel/clk sustained.
// Backpressure: s_ready drops only when both stages hold a pixel and m_ready is low; no drop/duplicate.
module dither_sequencer #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  dither_sequencer_if.slave     bus,
  output logic [7:0]            frame_cnt
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  logic          adv1, adv2, acc;
  logic [XW-1:0] x, px;
  logic [YW-1:0] y, py;
  logic          at_org, x_last, y_last;
  logic [1:0]    phase, idx;
  logic [3:0]    off_nxt;

  logic          v1;
  logic [23:0]   d1;
  logic [3:0]    off1;
  logic          sof1, eol1;

  assign adv2        = !bus.m_valid || bus.m_ready;
  assign adv1        = !v1 || adv2;
  assign bus.s_ready = adv1;
  assign acc         = bus.s_valid && adv1;

  assign at_org = (x == '0) && (y == '0);
  assign x_last = (x == XW'(H_RES - 1));
  assign y_last = (y == YW'(V_RES - 1));

  // A start-of-frame marker relocates the incoming pixel to the origin.
  assign px = bus.s_sof ? '0 : x;
  assign py = bus.s_sof ? '0 : y;

`ifdef DITHER_TEMPORAL_EN
  logic [7:0] fc_pix;
  // Phase follows the frame the pixel belongs to, including a frame opened by s_sof.
  assign fc_pix = (bus.s_sof && !at_org) ? frame_cnt + 8'd1 : frame_cnt;
  assign phase  = fc_pix[1:0];
`else
  assign phase  = 2'b00;
`endif

  assign idx = {py[0], px[0]} ^ phase;

  // Bayer 2x2 offset lookup, forced to zero for plain truncation.
  always_comb begin
    off_nxt = 4'd0;
    if (enable) begin
      case (idx)
        2'd0: off_nxt = 4'd0;
        2'd1: off_nxt = 4'd8;
        2'd2: off_nxt = 4'd12;
        default: off_nxt = 4'd4;
      endcase
    end
  end

  function automatic logic [3:0] sat_chan(input logic [7:0] c, input logic [3:0] off);
    logic [8:0] s;
    s = {1'b0, c} + {5'b0, off};
    return s[8] ? 4'hF : s[7:4];
  endfunction

  // Frame position and completed-frame counter, advanced on every accepted pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x         <= '0;
      y         <= '0;
      frame_cnt <= '0;
    end else if (acc) begin
      if (bus.s_sof) begin
        x <= XW'(1);
        y <= '0;
        if (!at_org) frame_cnt <= frame_cnt + 8'd1;
      end else if (x_last) begin
        x <= '0;
        if (y_last) begin
          y         <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          y <= y + YW'(1);
        end
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  // Stage 1: capture raw pixel, chosen offset and position flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1   <= 1'b0;
      d1   <= '0;
      off1 <= '0;
      sof1 <= 1'b0;
      eol1 <= 1'b0;
    end else if (adv1) begin
      v1 <= bus.s_valid;
      if (bus.s_valid) begin
        d1   <= bus.s_data;
        off1 <= off_nxt;
        sof1 <= (px == '0) && (py == '0);
        eol1 <= (px == XW'(H_RES - 1));
      end
    end
  end

  // Stage 2: apply offset with saturation and present the reduced pixel; held while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_sof   <= 1'b0;
      bus.m_eol   <= 1'b0;
    end else if (adv2) begin
      bus.m_valid <= v1;
      if (v1) begin
        bus.m_data <= {sat_chan(d1[23:16], off1), sat_chan(d1[15:8], off1), sat_chan(d1[7:0], off1)};
        bus.m_sof  <= sof1;
        bus.m_eol  <= eol1;
      end
    end
  end

endmodule

// File: tb/tb_dither_sequencer.sv
// Randomised and directed bench for dither_sequencer with a frame-position reference model.
module tb_dither_sequencer;
  localparam int H = 4;
  localparam int V = 2;
`ifdef DITHER_TEMPORAL_EN
  localparam bit TEMPORAL = 1'b1;
`else
  localparam bit TEMPORAL = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic [7:0] frame_cnt;

  dither_sequencer_if bus ();

  dither_sequencer #(.H_RES(H), .V_RES(V)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .bus       (bus),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: linear position inside the frame and frame count.
  int          pos;
  logic [7:0]  mfc;
  logic [13:0] expq[$];
  logic        held_vld;
  logic [13:0] held;
  int          in_cnt, out_cnt, sof_seen, eol_seen;
  logic [11:0] cap8;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] model_pix(input logic [23:0] d, input int px, input int py,
                                            input logic en, input int fc);
    int off_tab[4];
    int ph, i, off, v;
    logic [11:0] r;
    off_tab = '{0, 8, 12, 4};
    ph  = TEMPORAL ? (fc % 4) : 0;
    i   = ((py % 2) * 2 + (px % 2)) ^ ph;
    off = en ? off_tab[i] : 0;
    r   = '0;
    for (int c = 0; c < 3; c++) begin
      v = int'(d[c*8 +: 8]) + off;
      r[c*4 +: 4] = (v > 255) ? 4'hF : 4'(v / 16);
    end
    return r;
  endfunction

  // Compare outputs, check hold stability, and feed accepted inputs into the model.
  task automatic observe();
    logic [13:0] e;
    int px, py;
    chk("frame_cnt", 32'(frame_cnt), 32'(mfc));
    if (held_vld)
      chk("hold", {18'b0, bus.m_valid, bus.m_data, bus.m_sof}, {18'b0, 1'b1, held[13:1]});
    held_vld = bus.m_valid && !bus.m_ready;
    held     = {bus.m_data, bus.m_sof, bus.m_eol};
    if (bus.m_valid && bus.m_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_out: got %0h expected no output", bus.m_data);
      end else begin
        e = expq.pop_front();
        chk("m_data", 32'(bus.m_data), 32'(e[13:2]));
        chk("m_sof",  32'(bus.m_sof),  32'(e[1]));
        chk("m_eol",  32'(bus.m_eol),  32'(e[0]));
      end
      sof_seen += int'(bus.m_sof);
      eol_seen += int'(bus.m_eol);
      if (out_cnt == 8) cap8 = bus.m_data;
      out_cnt++;
    end
    if (bus.s_valid && bus.s_ready) begin
      if (bus.s_sof) begin
        if (pos != 0) mfc = mfc + 8'd1;
        pos = 0;
      end
      px = pos % H;
      py = pos / H;
      expq.push_back({model_pix(bus.s_data, px, py, enable, int'(mfc)),
                      (pos == 0), (px == H - 1)});
      pos++;
      if (pos == H * V) begin
        pos = 0;
        mfc = mfc + 8'd1;
      end
      in_cnt++;
    end
  endtask

  task automatic cyc(input logic sv, input logic [23:0] sd, input logic ss, input logic en, input logic mr);
    @(negedge clk);
    bus.s_valid = sv;
    bus.s_data  = sd;
    bus.s_sof   = ss;
    enable      = en;
    bus.m_ready = mr;
    #1;
    observe();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_data", 32'(bus.m_data), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    expq.delete();
    pos = 0; mfc = '0; held_vld = 1'b0;
    in_cnt = 0; out_cnt = 0; sof_seen = 0; eol_seen = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
  endtask

  initial begin
    reset_n = 1'b1;
    enable = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_sof = 1'b0; bus.m_ready = 1'b1;
    cap8 = '0;
    #2;

    // Pin the model against hand-computed values.
    chk("model_787878_x0", 32'(model_pix(24'h787878, 0, 0, 1'b1, 0)), 32'h777);
    chk("model_787878_x1", 32'(model_pix(24'h787878, 1, 0, 1'b1, 0)), 32'h888);
    chk("model_trunc", 32'(model_pix(24'h787878, 1, 0, 1'b0, 0)), 32'h777);
    chk("model_sat", 32'(model_pix(24'hFFF8F5, 0, 1, 1'b1, 0)), 32'hFFF);
    chk("model_off4", 32'(model_pix(24'h101010, 1, 1, 1'b1, 0)), 32'h111);

    do_reset();

    // Directed: latency, dither vs truncation, saturation.
    cyc(1'b1, 24'h787878, 1'b0, 1'b1, 1'b1);
    chk("lat_c0", 32'(bus.m_valid), 32'd0);
    cyc(1'b1, 24'h787878, 1'b0, 1'b1, 1'b1);
    chk("lat_c1", 32'(bus.m_valid), 32'd0);
    cyc(1'b1, 24'h787878, 1'b0, 1'b0, 1'b1);
    chk("lat_c2", 32'(bus.m_valid), 32'd1);
    chk("px0", 32'(bus.m_data), 32'h777);
    cyc(1'b1, 24'h787878, 1'b0, 1'b0, 1'b1);
    chk("px1", 32'(bus.m_data), 32'h888);
    cyc(1'b1, 24'hFFF8F5, 1'b0, 1'b1, 1'b1);
    chk("px2_trunc", 32'(bus.m_data), 32'h777);
    cyc(1'b1, 24'h101010, 1'b0, 1'b1, 1'b1);
    chk("px3_trunc", 32'(bus.m_data), 32'h777);
    cyc(1'b0, 24'h0, 1'b0, 1'b1, 1'b1);
    chk("px4_sat", 32'(bus.m_data), 32'hFFF);
    cyc(1'b0, 24'h0, 1'b0, 1'b1, 1'b1);
    chk("px5_off4", 32'(bus.m_data), 32'h111);

    // Two full frames: flags and frame counting.
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 24'h888888, 1'b0, 1'b1, 1'b1);
    repeat (3) cyc(1'b0, 24'h0, 1'b0, 1'b1, 1'b1);
    chk("sof_count", 32'(sof_seen), 32'd2);
    chk("eol_count", 32'(eol_seen), 32'd4);
    chk("frames_2", 32'(frame_cnt), 32'd2);
    chk("px8_phase", 32'(cap8), TEMPORAL ? 32'h999 : 32'h888);

    // Backpressure: five stalled cycles under continuous input.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 24'($urandom), 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 24'($urandom), 1'b0, 1'b1, 1'b0);
    chk("stall_s_ready", 32'(bus.s_ready), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 24'h0, 1'b0, 1'b1, 1'b1);
    chk("stall_in_eq_out", 32'(out_cnt), 32'(in_cnt));

    // Start-of-frame marker mid-line.
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1'b1, 24'($urandom), (i == 5), 1'b1, 1'b1);
    repeat (3) cyc(1'b0, 24'h0, 1'b0, 1'b1, 1'b1);
    chk("sof_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("sof_count_mid", 32'(sof_seen), 32'd2);

    // Random traffic with a mid-stream reset while both stages are full.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        repeat (3) cyc(1'b1, 24'($urandom), 1'b0, 1'b1, 1'b0);
        chk("full_before_rst", 32'(bus.s_ready), 32'd0);
        do_reset();
        cyc(1'b1, 24'($urandom), 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 24'h0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 24'h0, 1'b0, 1'b1, 1'b1);
        chk("post_rst_sof", 32'({bus.m_valid, bus.m_sof}), 32'b11);
      end
      cyc(($urandom_range(0, 3) != 0), 24'($urandom), ($urandom_range(0, 15) == 0),
          1'($urandom), ($urandom_range(0, 3) != 0));
    end
    repeat (4) cyc(1'b0, 24'h0, 1'b0, 1'b1, 1'b1);
    chk("final_in_eq_out", 32'(out_cnt), 32'(in_cnt));
    chk("final_queue_empty", 32'(expq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
